// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes,
// datapath select encodings, FSM state enum and the control word layout.
package mips_ctrl_pkg;

    // Opcode field values (instruction bits 31:26)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_AND   = 3'b101;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Branch condition evaluated by the datapath when pc_write_cond is set
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;
    localparam logic [1:0] BR_GTZ  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        R_EXEC,
        R_WB,
        IMM_EXEC,
        IMM_WB,
        BRANCH,
        JUMP,
        TRAP
    } mcuState_t;

    localparam int STATE_W = $bits(mcuState_t);

    // One control word per cycle; field order is the flattened bus order.
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       irWrite;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       memToReg;
        logic       regDst;
        logic       aluSrcA;
        logic       extZero;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic [1:0] branchCond;
        logic       illegalOp;
        logic       instrDone;
    } ctrlWord_t;

    localparam int CTRL_W = $bits(ctrlWord_t);

    // ALU operation for the I-type arithmetic/logic group
    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        case (op)
            OP_ANDI: immAluOp = ALU_AND;
            OP_ORI:  immAluOp = ALU_OR;
            OP_SLTI: immAluOp = ALU_SLT;
            default: immAluOp = ALU_ADD;
        endcase
    endfunction

    // Logical immediates are zero-extended, everything else sign-extended
    function automatic logic isZeroExt(input logic [5:0] op);
        isZeroExt = (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    // Branch condition for the branch group
    function automatic logic [1:0] branchCondOf(input logic [5:0] op);
        case (op)
            OP_BEQ:  branchCondOf = BR_EQ;
            OP_BNE:  branchCondOf = BR_NE;
            OP_BGTZ: branchCondOf = BR_GTZ;
            default: branchCondOf = BR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mcu_output_decoder.sv
// Combinational state -> control word table for the multi-cycle control unit.
// Outputs depend on the registered state and latched opcode; the only live
// input is the memory completion strobe, which qualifies the one-shot
// IR/PC write in FETCH and the final-state flag of a store.
module mcu_output_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [STATE_W-1:0] stateBits,
    input  logic [OP_W-1:0]    opLatched,
    input  logic               memReady,
    output logic [CTRL_W-1:0]  ctrlBits
);

    ctrlWord_t  word;
    logic [5:0] op;

    assign op       = 6'(opLatched);
    assign ctrlBits = word;

    // Decode one control word per state; anything not set is 0
    always_comb begin
        word = '0;
        case (mcuState_t'(stateBits))
            FETCH: begin
                word.memRead  = 1'b1;
                word.aluSrcB  = SRCB_FOUR;
                word.aluOp    = ALU_ADD;
                word.pcSource = PCSRC_ALU;
                word.irWrite  = memReady;
                word.pcWrite  = memReady;
            end
            DECODE: begin
                word.aluSrcB = SRCB_IMM_SHL2;
                word.aluOp   = ALU_ADD;
            end
            MEM_ADDR: begin
                word.aluSrcA = 1'b1;
                word.aluSrcB = SRCB_IMM;
                word.aluOp   = ALU_ADD;
            end
            MEM_READ: begin
                word.memRead = 1'b1;
                word.iOrD    = 1'b1;
            end
            MEM_WB: begin
                word.regWrite  = 1'b1;
                word.memToReg  = 1'b1;
                word.instrDone = 1'b1;
            end
            MEM_WRITE: begin
                word.memWrite  = 1'b1;
                word.iOrD      = 1'b1;
                word.instrDone = memReady;
            end
            R_EXEC: begin
                word.aluSrcA = 1'b1;
                word.aluSrcB = SRCB_REGB;
                word.aluOp   = ALU_FUNCT;
            end
            R_WB: begin
                word.regWrite  = 1'b1;
                word.regDst    = 1'b1;
                word.instrDone = 1'b1;
            end
            IMM_EXEC: begin
                word.aluSrcA = 1'b1;
                word.aluSrcB = SRCB_IMM;
                word.aluOp   = immAluOp(op);
                word.extZero = isZeroExt(op);
            end
            IMM_WB: begin
                word.regWrite  = 1'b1;
                word.instrDone = 1'b1;
            end
            BRANCH: begin
                word.aluSrcA     = 1'b1;
                word.aluSrcB     = SRCB_REGB;
                word.aluOp       = ALU_SUB;
                word.pcWriteCond = 1'b1;
                word.pcSource    = PCSRC_ALUOUT;
                word.branchCond  = branchCondOf(op);
                word.instrDone   = 1'b1;
            end
            JUMP: begin
                word.pcWrite   = 1'b1;
                word.pcSource  = PCSRC_JUMP;
                word.instrDone = 1'b1;
            end
            TRAP: begin
                word.illegalOp = 1'b1;
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB,
// opcode latch, and a retired-instruction counter.
//
// Memory handshake: mem_ready is a completion strobe. In FETCH, MEM_READ and
// MEM_WRITE the access is held (state and strobes unchanged) until a cycle
// with mem_ready=1; that cycle completes the access and the FSM advances on
// the following edge. mem_ready in any other state has no effect.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int ALUOP_W       = 3,
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op_code,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               alu_src_a,
    output logic               ext_zero,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic [1:0]         branch_cond,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retire_count
);

    mcuState_t         state;
    mcuState_t         stateNext;
    logic [OP_W-1:0]   opLatched;
    logic [CNT_W-1:0]  retireCount;
    logic              memReadyEff;
    logic [CTRL_W-1:0] ctrlBits;
    ctrlWord_t         ctrl;

    // With the handshake disabled every access completes in one cycle
    assign memReadyEff = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Capture the opcode in DECODE so later states ignore IR changes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opLatched <= '0;
        end else if (state == DECODE) begin
            opLatched <= op_code;
        end
    end

    // Next-state logic; DECODE dispatches on the live opcode
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     stateNext = FETCH;
            FETCH:    if (memReadyEff) stateNext = DECODE;
            DECODE: begin
                case (op_code)
                    OP_W'(OP_RTYPE):                  stateNext = R_EXEC;
                    OP_W'(OP_LW), OP_W'(OP_SW):       stateNext = MEM_ADDR;
                    OP_W'(OP_BEQ), OP_W'(OP_BNE),
                    OP_W'(OP_BGTZ):                   stateNext = BRANCH;
                    OP_W'(OP_ADDI), OP_W'(OP_ANDI),
                    OP_W'(OP_ORI), OP_W'(OP_SLTI):    stateNext = IMM_EXEC;
                    OP_W'(OP_J):                      stateNext = JUMP;
                    default:                          stateNext = TRAP;
                endcase
            end
            MEM_ADDR: stateNext = (opLatched == OP_W'(OP_SW)) ? MEM_WRITE : MEM_READ;
            MEM_READ: if (memReadyEff) stateNext = MEM_WB;
            MEM_WB:   stateNext = FETCH;
            MEM_WRITE: if (memReadyEff) stateNext = FETCH;
            R_EXEC:   stateNext = R_WB;
            R_WB:     stateNext = FETCH;
            IMM_EXEC: stateNext = IMM_WB;
            IMM_WB:   stateNext = FETCH;
            BRANCH:   stateNext = FETCH;
            JUMP:     stateNext = FETCH;
            TRAP:     stateNext = FETCH;
            default:  stateNext = IDLE;
        endcase
    end

    mcu_output_decoder #(
        .OP_W (OP_W)
    ) uDecoder (
        .stateBits (state),
        .opLatched (opLatched),
        .memReady  (memReadyEff),
        .ctrlBits  (ctrlBits)
    );

    assign ctrl = ctrlWord_t'(ctrlBits);

    // Count instructions on their final cycle; wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retireCount <= '0;
        end else if (ctrl.instrDone) begin
            retireCount <= retireCount + 1'b1;
        end
    end

    assign pc_write      = ctrl.pcWrite;
    assign pc_write_cond = ctrl.pcWriteCond;
    assign ir_write      = ctrl.irWrite;
    assign i_or_d        = ctrl.iOrD;
    assign mem_read      = ctrl.memRead;
    assign mem_write     = ctrl.memWrite;
    assign reg_write     = ctrl.regWrite;
    assign mem_to_reg    = ctrl.memToReg;
    assign reg_dst       = ctrl.regDst;
    assign alu_src_a     = ctrl.aluSrcA;
    assign ext_zero      = ctrl.extZero;
    assign alu_src_b     = ctrl.aluSrcB;
    assign alu_op        = ALUOP_W'(ctrl.aluOp);
    assign pc_source     = ctrl.pcSource;
    assign branch_cond   = ctrl.branchCond;
    assign illegal_op    = ctrl.illegalOp;
    assign instr_done    = ctrl.instrDone;
    assign retire_count  = retireCount;

endmodule
